instruction_fetch_stage: RTL and testbench

Fetch stage of the LEGv8 datapath, directly upstream of the byte-addressed, big-endian instruction memory. It owns the program counter and drives it as the memory's 64-bit address. It captures the returned 32-bit instruction word into the IF/ID pipeline register for decode. It handles start-up, hazard stalls and branch redirects.

---
 rtl/fetch_pkg.sv | 28 ++
 rtl/ifid_register.sv | 35 +++
 rtl/instruction_fetch_stage.sv | 128 ++++++++++++
 tb/tb_instruction_fetch_stage.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the LEGv8 instruction fetch stage: FSM state
// encoding, address/instruction widths, the flush bubble word and an
// address alignment helper.
package fetch_pkg;

  localparam int ADDR_W      = 64;
  localparam int INSTR_W     = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [INSTR_W-1:0] BUBBLE_INSTR = 32'h0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetchState_t;

  // Clears the byte-offset bits so the address names a whole instruction.
  function automatic logic [ADDR_W-1:0] alignAddr(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(INSTR_BYTES - 1);
  endfunction

  // True when the address does not fall on an instruction boundary.
  function automatic logic isMisaligned(input logic [ADDR_W-1:0] addr);
    return (addr & ADDR_W'(INSTR_BYTES - 1)) != '0;
  endfunction

endpackage

// File: rtl/ifid_register.sv
// IF/ID pipeline register. Holds the fetched instruction, its address and
// a valid bit. flush has priority over load; with neither asserted the
// register holds (this is how a hazard stall freezes decode input).
module ifid_register
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               flush,
  input  logic [INSTR_W-1:0] instrIn,
  input  logic [ADDR_W-1:0]  pcIn,
  output logic [INSTR_W-1:0] ifidInstruction,
  output logic [ADDR_W-1:0]  ifidPc,
  output logic               ifidValid
);

  // Capture, bubble or hold the IF/ID contents on each edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifidInstruction <= BUBBLE_INSTR;
      ifidPc          <= '0;
      ifidValid       <= 1'b0;
    end else if (flush) begin
      // The address is left alone: it is meaningless while valid is low.
      ifidInstruction <= BUBBLE_INSTR;
      ifidValid       <= 1'b0;
    end else if (load) begin
      ifidInstruction <= instrIn;
      ifidPc          <= pcIn;
      ifidValid       <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// LEGv8 instruction fetch stage. Owns the program counter (driven straight
// out as the instruction memory address), sequences IDLE -> RUN on start,
// and steers the IF/ID register for sequential fetch, hazard stall and
// branch redirect (redirect wins over stall and inserts one bubble).
//
// Optional feature: define FETCH_ALIGN_CHECK_EN to trap branch targets that
// are not word aligned into a sticky FAULT state. Without it the low two
// target bits are silently cleared and fault is tied low.
module instruction_fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 64'h0,
  parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(INSTR_BYTES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic [INSTR_W-1:0] imem_instruction,
  output logic [ADDR_W-1:0]  imem_pc,
  output logic [INSTR_W-1:0] ifid_instruction,
  output logic [ADDR_W-1:0]  ifid_pc,
  output logic               ifid_valid,
  output logic               running,
  output logic               fault
);

  fetchState_t       state;
  fetchState_t       nextState;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pcNext;
  logic [ADDR_W-1:0] branchPc;
  logic              badBranch;
  logic              loadIfid;
  logic              flushIfid;

`ifdef FETCH_ALIGN_CHECK_EN
  // A misaligned redirect is trapped rather than followed.
  assign badBranch = isMisaligned(branch_target);
  assign branchPc  = branch_target;
`else
  // Misaligned redirects are forced onto the enclosing word.
  assign badBranch = 1'b0;
  assign branchPc  = alignAddr(branch_target);
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic: start only matters in IDLE; FAULT is left only via reset.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (start) nextState = RUN;
      RUN:     if (branch_taken && badBranch) nextState = FAULT;
      FAULT:   nextState = FAULT;
      default: nextState = IDLE;
    endcase
  end

  // Datapath controls: PC source and IF/ID load/flush, redirect > stall > fetch.
  always_comb begin
    pcNext    = pc;
    loadIfid  = 1'b0;
    flushIfid = 1'b0;
    unique case (state)
      IDLE: begin
        pcNext    = RESET_PC;
        flushIfid = 1'b1;
      end
      RUN: begin
        if (branch_taken) begin
          flushIfid = 1'b1;
          if (!badBranch) pcNext = branchPc;
        end else if (!stall) begin
          loadIfid = 1'b1;
          pcNext   = pc + PC_STEP;
        end
      end
      FAULT: begin
        flushIfid = 1'b1;
      end
      default: begin
        pcNext    = RESET_PC;
        flushIfid = 1'b1;
      end
    endcase
  end

  // Program counter register; 64-bit add wraps without any flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else begin
      pc <= pcNext;
    end
  end

  ifid_register uIfid (
    .clk             (clk),
    .reset           (reset),
    .load            (loadIfid),
    .flush           (flushIfid),
    .instrIn         (imem_instruction),
    .pcIn            (pc),
    .ifidInstruction (ifid_instruction),
    .ifidPc          (ifid_pc),
    .ifidValid       (ifid_valid)
  );

  assign imem_pc = pc;
  assign running = (state == RUN);

`ifdef FETCH_ALIGN_CHECK_EN
  assign fault = (state == FAULT);
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage. A behavioural model of
// the fetch rules (IDLE/RUN/FAULT, redirect > stall > fetch) tracks the
// expected outputs; directed scenarios use hand-derived constants.
module tb_instruction_fetch_stage;

  localparam logic [63:0] RESET_PC = 64'h0;
  localparam logic [63:0] PC_STEP  = 64'd4;
`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic [31:0] imem_instruction;
  logic [63:0] imem_pc;
  logic [31:0] ifid_instruction;
  logic [63:0] ifid_pc;
  logic        ifid_valid;
  logic        running;
  logic        fault;

  int tests = 0;
  int fails = 0;

  // Reference model state (0 = idle, 1 = run, 2 = fault).
  int          mState;
  logic [63:0] mPc;
  logic [63:0] mIfPc;
  logic [31:0] mInstr;
  logic        mValid;

  instruction_fetch_stage #(.RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .stall            (stall),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .imem_instruction (imem_instruction),
    .imem_pc          (imem_pc),
    .ifid_instruction (ifid_instruction),
    .ifid_pc          (ifid_pc),
    .ifid_valid       (ifid_valid),
    .running          (running),
    .fault            (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: two fixed words, a hash elsewhere.
  function automatic logic [31:0] memWord(input logic [63:0] a);
    if (a == 64'h0) return 32'hF842802A;
    if (a == 64'h4) return 32'hCB03804B;
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5A5A0000;
  endfunction

  always_comb imem_instruction = memWord(imem_pc);

  task automatic modelReset();
    mState = 0;
    mPc    = RESET_PC;
    mIfPc  = 64'h0;
    mInstr = 32'h0;
    mValid = 1'b0;
  endtask

  task automatic modelStep();
    if (reset) begin
      modelReset();
    end else begin
      case (mState)
        0: begin
          mPc = RESET_PC; mValid = 1'b0; mInstr = 32'h0;
          if (start) mState = 1;
        end
        1: begin
          if (branch_taken) begin
            mValid = 1'b0; mInstr = 32'h0;
            if (ALIGN_CHECK && (branch_target % 4) != 0) mState = 2;
            else mPc = branch_target - (branch_target % 4);
          end else if (!stall) begin
            mInstr = memWord(mPc);
            mIfPc  = mPc;
            mValid = 1'b1;
            mPc    = mPc + PC_STEP;
          end
        end
        default: mValid = 1'b0;
      endcase
    end
  endtask

  // Advance one clock: model follows the edge, outputs sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 64'h0;
    modelReset();
    tick(); tick();
    tests++; if (imem_pc !== RESET_PC) begin fails++; $display("FAIL reset_pc: got %h want %h", imem_pc, RESET_PC); end
    tests++; if (ifid_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", ifid_valid); end
    tests++; if (ifid_pc !== 64'h0) begin fails++; $display("FAIL reset_ifid_pc: got %h want 0", ifid_pc); end
    tests++; if (ifid_instruction !== 32'h0) begin fails++; $display("FAIL reset_instr: got %h want 0", ifid_instruction); end
    tests++; if ({running, fault} !== 2'b00) begin fails++; $display("FAIL reset_flags: got %b want 00", {running, fault}); end
    reset = 1'b0;
    // Branch and stall must be ignored while idle.
    branch_taken = 1'b1; branch_target = 64'h40; stall = 1'b1;
    tick();
    tests++; if ({imem_pc, ifid_valid, running} !== {RESET_PC, 2'b00}) begin fails++; $display("FAIL idle_ignore: got pc %h v%b r%b want pc %h v0 r0", imem_pc, ifid_valid, running, RESET_PC); end
    branch_taken = 1'b0; stall = 1'b0;
  endtask

  task automatic test_start();
    start = 1'b1;
    tick();
    tests++; if ({running, ifid_valid} !== 2'b10) begin fails++; $display("FAIL start_edge1: got r%b v%b want r1 v0", running, ifid_valid); end
    tests++; if (imem_pc !== 64'h0) begin fails++; $display("FAIL start_pc1: got %h want 0", imem_pc); end
    start = 1'b0;
    tick();
    tests++; if ({ifid_valid, ifid_pc, ifid_instruction} !== {1'b1, 64'h0, 32'hF842802A}) begin fails++; $display("FAIL start_fetch0: got v%b pc %h ins %h want v1 pc 0 ins f842802a", ifid_valid, ifid_pc, ifid_instruction); end
    tests++; if (imem_pc !== 64'h4) begin fails++; $display("FAIL start_pc2: got %h want 4", imem_pc); end
    tick();
    tests++; if ({ifid_valid, ifid_pc, ifid_instruction} !== {1'b1, 64'h4, 32'hCB03804B}) begin fails++; $display("FAIL start_fetch4: got v%b pc %h ins %h want v1 pc 4 ins cb03804b", ifid_valid, ifid_pc, ifid_instruction); end
    tests++; if (imem_pc !== 64'h8) begin fails++; $display("FAIL start_pc3: got %h want 8", imem_pc); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (imem_pc !== 64'h8) begin fails++; $display("FAIL stall_pc[%0d]: got %h want 8", i, imem_pc); end
      tests++; if ({ifid_valid, ifid_pc, ifid_instruction} !== {1'b1, 64'h4, 32'hCB03804B}) begin fails++; $display("FAIL stall_hold[%0d]: got v%b pc %h ins %h want v1 pc 4 ins cb03804b", i, ifid_valid, ifid_pc, ifid_instruction); end
    end
    stall = 1'b0;
    tick();
    tests++; if ({ifid_pc, ifid_instruction, imem_pc} !== {64'h8, memWord(64'h8), 64'hC}) begin fails++; $display("FAIL stall_resume: got pc %h ins %h next %h want pc 8 ins %h next c", ifid_pc, ifid_instruction, imem_pc, memWord(64'h8)); end
  endtask

  task automatic test_branch_stall();
    branch_taken = 1'b1; stall = 1'b1; branch_target = 64'h40;
    tick();
    tests++; if ({imem_pc, ifid_valid, ifid_instruction} !== {64'h40, 1'b0, 32'h0}) begin fails++; $display("FAIL branch_flush: got pc %h v%b ins %h want pc 40 v0 ins 0", imem_pc, ifid_valid, ifid_instruction); end
    branch_taken = 1'b0; stall = 1'b0;
    tick();
    tests++; if ({ifid_valid, ifid_pc, ifid_instruction} !== {1'b1, 64'h40, memWord(64'h40)}) begin fails++; $display("FAIL branch_target: got v%b pc %h ins %h want v1 pc 40 ins %h", ifid_valid, ifid_pc, ifid_instruction, memWord(64'h40)); end
    tests++; if (imem_pc !== 64'h44) begin fails++; $display("FAIL branch_next: got %h want 44", imem_pc); end
  endtask

  task automatic test_wrap();
    branch_taken = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    branch_taken = 1'b0;
    tick();
    tests++; if (imem_pc !== 64'h0) begin fails++; $display("FAIL wrap_pc: got %h want 0", imem_pc); end
    tests++; if ({ifid_valid, ifid_pc} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFC}) begin fails++; $display("FAIL wrap_ifid: got v%b pc %h want v1 pc fffffffffffffffc", ifid_valid, ifid_pc); end
  endtask

  task automatic test_random();
    logic [162:0] got;
    logic [162:0] want;
    for (int i = 0; i < 400; i++) begin
      stall         = ($urandom_range(0, 3) == 0);
      branch_taken  = ($urandom_range(0, 7) == 0);
      start         = $urandom_range(0, 1) == 1;
      branch_target = {$urandom, $urandom} & ~64'h3;
      if ($urandom_range(0, 9) == 0) branch_target = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 3) * 4);
      tick();
      got  = {imem_pc, ifid_pc, ifid_instruction, ifid_valid, running, fault};
      want = {mPc, mIfPc, mInstr, mValid, mState == 1, mState == 2};
      tests++; if (got !== want) begin fails++; $display("FAIL random[%0d]: got %h want %h", i, got, want); end
    end
    stall = 1'b0; branch_taken = 1'b0; start = 1'b0;
  endtask

  task automatic test_misaligned();
    branch_taken = 1'b1; branch_target = 64'h100;
    tick();
    branch_target = 64'h42; start = 1'b1;
    tick();
    if (ALIGN_CHECK) begin
      tests++; if ({imem_pc, fault, running, ifid_valid} !== {64'h100, 3'b100}) begin fails++; $display("FAIL misalign_trap: got pc %h f%b r%b v%b want pc 100 f1 r0 v0", imem_pc, fault, running, ifid_valid); end
    end else begin
      tests++; if ({imem_pc, fault, running, ifid_valid} !== {64'h40, 3'b010}) begin fails++; $display("FAIL misalign_clear: got pc %h f%b r%b v%b want pc 40 f0 r1 v0", imem_pc, fault, running, ifid_valid); end
    end
    branch_taken = 1'b0;
    tick(); tick();
    start = 1'b0;
    if (ALIGN_CHECK) begin
      tests++; if ({imem_pc, fault, ifid_valid} !== {64'h100, 2'b10}) begin fails++; $display("FAIL fault_sticky: got pc %h f%b v%b want pc 100 f1 v0", imem_pc, fault, ifid_valid); end
    end else begin
      tests++; if ({imem_pc, ifid_pc, ifid_valid} !== {64'h48, 64'h44, 1'b1}) begin fails++; $display("FAIL misalign_run: got pc %h ifid %h v%b want pc 48 ifid 44 v1", imem_pc, ifid_pc, ifid_valid); end
    end
  endtask

  task automatic test_async_reset();
    start = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    modelReset();
    tests++; if ({imem_pc, ifid_pc, ifid_instruction, ifid_valid, running, fault} !== {RESET_PC, 64'h0, 32'h0, 3'b000}) begin fails++; $display("FAIL async_reset: got pc %h ifid %h ins %h v%b r%b f%b want all reset", imem_pc, ifid_pc, ifid_instruction, ifid_valid, running, fault); end
    #2;
    reset = 1'b0;
    branch_taken = 1'b1; branch_target = 64'h80;
    for (int i = 0; i < 3; i++) begin
      stall = $urandom_range(0, 1) == 1;
      tick();
      tests++; if ({imem_pc, running, ifid_valid} !== {RESET_PC, 2'b00}) begin fails++; $display("FAIL post_reset_idle[%0d]: got pc %h r%b v%b want pc %h r0 v0", i, imem_pc, running, ifid_valid, RESET_PC); end
    end
    branch_taken = 1'b0; stall = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tests++; if ({ifid_valid, ifid_pc, ifid_instruction} !== {1'b1, 64'h0, 32'hF842802A}) begin fails++; $display("FAIL restart_fetch: got v%b pc %h ins %h want v1 pc 0 ins f842802a", ifid_valid, ifid_pc, ifid_instruction); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_stall();
    test_branch_stall();
    test_wrap();
    test_random();
    test_misaligned();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
